// File: rtl/mac_acumulador_sat_if.sv
// Product/result bus for mac_acumulador_sat.
//   prod_valid, prod (2N signed), prod_ready : product stream from the multiplier
//   out_valid, out_data (N signed), out_ready : rounded, saturated result stream
//   sat                                        : sticky saturation flag
// master: the side that feeds products and consumes results.
// slave:  the accumulator itself.
interface mac_acumulador_sat_if #(
  parameter int unsigned N = 16
);
  logic                  prod_valid;
  logic signed [2*N-1:0] prod;
  logic                  prod_ready;
  logic                  out_valid;
  logic signed [N-1:0]   out_data;
  logic                  out_ready;
  logic                  sat;

  modport master (
    output prod_valid, prod, out_ready,
    input  prod_ready, out_valid, out_data, sat
  );

  modport slave (
    input  prod_valid, prod, out_ready,
    output prod_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/mac_acumulador_sat.sv
// Accumulator, half-up rounder and saturator for a signed multiplier output.
// Sums TAPS consecutive 2N-bit products, rounds, drops FRAC fractional bits,
// clamps to N bits and holds the result on a valid/ready output.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (also clears out_data)
//   clear : synchronous active-high flush, below rst_n in priority
//   bus   : product input, result output and sticky sat flag (slave modport)
module mac_acumulador_sat #(
  parameter int unsigned N    = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned TAPS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  mac_acumulador_sat_if.slave  bus
);

  // One guard bit beyond the TAPS growth leaves room for the rounding add.
  localparam int unsigned AccW = 2 * N + $clog2(TAPS) + 1;
  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned RndSh = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [CntW-1:0] LastTap = CntW'(TAPS - 1);
  localparam logic signed [AccW-1:0] RndAdd =
      (FRAC > 0) ? (AccW'(1) << RndSh) : '0;
  localparam logic signed [AccW-1:0] MaxV = {{(AccW - N + 1){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [AccW-1:0] MinV = {{(AccW - N + 1){1'b1}}, {(N - 1){1'b0}}};

  // The state is exactly the out_valid flag.
  localparam logic StAccum = 1'b0;
  localparam logic StHold  = 1'b1;

  logic                   state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic signed [N-1:0]    out_data_q, out_data_d;
  logic                   sat_q, sat_d;
  // Low through reset so prod_ready never depends on rst_n combinationally.
  logic                   rdy_q;

  logic signed [AccW-1:0] prod_ext;
  logic signed [AccW-1:0] sum;
  logic signed [AccW-1:0] rnd;
  logic signed [AccW-1:0] shifted;
  logic signed [N-1:0]    clamped;
  logic                   clamp_hit;
  logic                   accept;

  assign prod_ext = $signed({{(AccW - 2 * N){bus.prod[2*N-1]}}, bus.prod});
  assign sum      = acc_q + prod_ext;
  assign rnd      = sum + RndAdd;
  assign shifted  = rnd >>> FRAC;

  always_comb begin
    clamped   = shifted[N-1:0];
    clamp_hit = 1'b0;
    if (shifted > MaxV) begin
      clamped   = MaxV[N-1:0];
      clamp_hit = 1'b1;
    end else if (shifted < MinV) begin
      clamped   = MinV[N-1:0];
      clamp_hit = 1'b1;
    end
  end

  assign bus.prod_ready = rdy_q && (state_q == StAccum);
  assign bus.out_valid  = (state_q == StHold);
  assign bus.out_data   = out_data_q;
  assign bus.sat        = sat_q;
  assign accept         = bus.prod_valid && bus.prod_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    case (state_q)
      StAccum: begin
        if (accept) begin
          if (cnt_q == LastTap) begin
            state_d    = StHold;
            acc_d      = '0;
            cnt_d      = '0;
            out_data_d = clamped;
            if (clamp_hit) sat_d = 1'b1;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (bus.out_ready) state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else if (clear) begin
      // out_data is left as is; out_valid dropping discards it.
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      rdy_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_acumulador_sat.sv
// Randomized scoreboard bench for mac_acumulador_sat (N=16, FRAC=8, TAPS=4).
module tb_mac_acumulador_sat;

  localparam int N    = 16;
  localparam int FRAC = 8;
  localparam int TAPS = 4;
  localparam longint Half = longint'(1) << (FRAC - 1);
  localparam longint Div  = longint'(1) << FRAC;
  localparam longint MaxO = (longint'(1) << (N - 1)) - 1;
  localparam longint MinO = -(longint'(1) << (N - 1));

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clear;
  int   mode;       // 0: out_ready=1, 1: random, 2: out_ready=0
  int   n_checks;
  int   n_pass;
  longint last_out;
  bit   sat_m;
  int   part[$];
  exp_t exp_q[$];

  mac_acumulador_sat_if #(.N(N)) bus ();

  mac_acumulador_sat #(.N(N), .FRAC(FRAC), .TAPS(TAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: floor((sum + half) / 2^FRAC), then clamp to N-bit signed range.
  task automatic model_group();
    longint s;
    longint num;
    longint r;
    exp_t   e;
    s = 0;
    foreach (part[i]) s += longint'(part[i]);
    num = s + Half;
    r = num / Div;
    if ((num % Div != 0) && (num < 0)) r -= 1;
    e.data = r;
    if (r > MaxO) begin
      e.data = MaxO;
      sat_m  = 1'b1;
    end else if (r < MinO) begin
      e.data = MinO;
      sat_m  = 1'b1;
    end
    e.sat = sat_m;
    exp_q.push_back(e);
    part.delete();
  endtask

  task automatic model_flush();
    part.delete();
    exp_q.delete();
    sat_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int gap);
    bit a;
    repeat (gap) tick();
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      a = bus.prod_valid && bus.prod_ready;
      tick();
      if (a) begin
        bus.prod_valid = 1'b0;
        part.push_back(p);
        if (part.size() == TAPS) begin
          model_group();
          check("latency_out_valid", longint'(bus.out_valid), 1);
          check("hold_prod_ready", longint'(bus.prod_ready), 0);
        end
        return;
      end
    end
    bus.prod_valid = 1'b0;
    check("accept_timeout", 0, 1);
  endtask

  task automatic send_group(input int p0, input int p1, input int p2, input int p3,
                            input int gap);
    send(p0, gap);
    send(p1, gap);
    send(p2, gap);
    send(p3, gap);
  endtask

  // Directed result check: only used with out_ready held high.
  task automatic group_expect(input string name, input int p0, input int p1, input int p2,
                              input int p3, input int gap, input longint req);
    send_group(p0, p1, p2, p3, gap);
    tick();
    check(name, last_out, req);
  endtask

  function automatic int rand_prod();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 2000)) - 1000;
      1:       return int'($urandom);
      2:       return ($urandom_range(0, 1) != 0) ? (1 << 30) : -(1 << 30);
      default: return int'($urandom_range(0, 2 << 20)) - (1 << 20);
    endcase
  endfunction

  // Output handshake driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      tick();
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: compare on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
        last_out = longint'(bus.out_data);
        if (exp_q.size() == 0) begin
          check("unexpected_output", longint'(bus.out_data), -99999);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_data", longint'(bus.out_data), e.data);
          check("sb_sat", longint'(bus.sat), longint'(e.sat));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_checks = 0;
    n_pass   = 0;
    last_out = 0;
    sat_m    = 1'b0;
    mode     = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prod_ready", longint'(bus.prod_ready), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_sat", longint'(bus.sat), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready_low", longint'(bus.prod_ready), 0);
    @(negedge clk);
    check("post_rst_prod_ready", longint'(bus.prod_ready), 1);
    tick();

    // Nominal.
    group_expect("nominal", 65536, 65536, 65536, 65536, 0, 1024);
    check("nominal_sat", longint'(bus.sat), 0);

    // Rounding half-up.
    group_expect("round_384", 128, 128, 128, 0, 0, 2);
    group_expect("round_127", 127, 0, 0, 0, 0, 0);
    group_expect("round_m128", -128, 0, 0, 0, 0, 0);
    group_expect("round_m129", -129, 0, 0, 0, 0, -1);

    // Saturation both ways; sat is sticky.
    group_expect("sat_pos", 1 << 30, 1 << 30, 1 << 30, 1 << 30, 0, 32767);
    check("sat_pos_flag", longint'(bus.sat), 1);
    group_expect("sat_neg", -(1 << 30), -(1 << 30), -(1 << 30), -(1 << 30), 0, -32768);
    check("sat_neg_flag", longint'(bus.sat), 1);

    // Backpressure.
    mode = 2;
    tick();
    tick();
    send_group(256, 256, 256, 256, 0);
    bus.prod_valid = 1'b1;
    bus.prod       = 12345;
    repeat (3) begin
      @(negedge clk);
      check("bp_prod_ready", longint'(bus.prod_ready), 0);
      check("bp_out_valid", longint'(bus.out_valid), 1);
      check("bp_out_data", longint'(bus.out_data), 4);
      tick();
    end
    bus.prod_valid = 1'b0;
    mode = 0;
    t = 0;
    while (bus.out_valid && t < 20) begin
      tick();
      t++;
    end
    check("bp_release", longint'(bus.out_valid), 0);
    check("bp_popped", last_out, 4);
    group_expect("bp_next_group", 1000, 2000, 3000, 4000, 0, 39);

    // Gaps between taps.
    group_expect("gaps", 65536, 65536, 65536, 65536, 2, 1024);

    // Clear mid-accumulation, with a product offered in the clear cycle.
    check("pre_clear_sat", longint'(bus.sat), 1);
    send(65536, 0);
    send(65536, 0);
    clear = 1'b1;
    bus.prod_valid = 1'b1;
    bus.prod       = 65536;
    tick();
    clear = 1'b0;
    bus.prod_valid = 1'b0;
    model_flush();
    @(negedge clk);
    check("clear_sat", longint'(bus.sat), 0);
    check("clear_out_valid", longint'(bus.out_valid), 0);
    check("clear_prod_ready", longint'(bus.prod_ready), 1);
    tick();
    group_expect("after_clear", 256, 256, 256, 256, 0, 4);

    // Reset mid-accumulation.
    send(65536, 0);
    send(65536, 0);
    rst_n = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 65536;
    tick();
    tick();
    model_flush();
    @(negedge clk);
    check("midrst_prod_ready", longint'(bus.prod_ready), 0);
    check("midrst_out_data", longint'(bus.out_data), 0);
    check("midrst_sat", longint'(bus.sat), 0);
    tick();
    rst_n = 1'b1;
    bus.prod_valid = 1'b0;
    tick();
    group_expect("after_reset", 256, 256, 256, 256, 0, 4);

    // Randomized groups with random gaps and random backpressure.
    mode = 1;
    repeat (40) begin
      send_group(rand_prod(), rand_prod(), rand_prod(), rand_prod(),
                 int'($urandom_range(0, 2)));
    end
    mode = 0;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 50) begin
      tick();
      t++;
    end
    check("drain_queue", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
